// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared types and constants for the nibble-serial magnitude comparator.
package serial_mag_compare_ctrl_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // One-hot cascade result: equal / less / greater.
    typedef struct packed {
        logic e;
        logic l;
        logic g;
    } cmp_res_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE;
    endfunction

endpackage

// File: rtl/serial_mag_compare_ctrl_comp4.sv
// 4-bit cascadable magnitude comparator; cascade inputs only matter when a == b.
module comp4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       inE,
    input  logic       inL,
    input  logic       inG,
    output logic       outE,
    output logic       outL,
    output logic       outG
);

    always_comb begin
        outE = 1'b0;
        outL = 1'b0;
        outG = 1'b0;
        if (a > b) begin
            outG = 1'b1;
        end else if (a < b) begin
            outL = 1'b1;
        end else begin
            outE = inE;
            outL = inL;
            outG = inG;
        end
    end

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Compares two WIDTH-bit operands one nibble per cycle, MS nibble first,
// exiting as soon as a nibble differs.
module serial_mag_compare_ctrl
    import serial_mag_compare_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            signed_mode,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    output logic                            busy,
    output logic                            done,
    output logic                            eq,
    output logic                            lt,
    output logic                            gt,
    output logic [$clog2(WIDTH/NIBBLE):0]   nibbles_used
);

    localparam int NNIB  = nib_count(WIDTH);
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int CNT_W = $clog2(NNIB) + 1;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               signed_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               eq_reg;
    logic               lt_reg;
    logic               gt_reg;

    logic [NIBBLE-1:0]  a_nib [NNIB];
    logic [NIBBLE-1:0]  b_nib [NNIB];
    logic [NIBBLE-1:0]  a_sel;
    logic [NIBBLE-1:0]  b_sel;
    cmp_res_t           res;

    // Flipping the sign bit of the top nibble maps two's-complement order
    // onto unsigned order, so the rest of the datapath stays unsigned.
    genvar gi;
    generate
        for (gi = 0; gi < NNIB; gi++) begin : g_nib
            if (gi == NNIB - 1) begin : g_msn
                assign a_nib[gi] = {a_reg[gi*NIBBLE+3] ^ signed_reg, a_reg[gi*NIBBLE +: 3]};
                assign b_nib[gi] = {b_reg[gi*NIBBLE+3] ^ signed_reg, b_reg[gi*NIBBLE +: 3]};
            end else begin : g_lsn
                assign a_nib[gi] = a_reg[gi*NIBBLE +: NIBBLE];
                assign b_nib[gi] = b_reg[gi*NIBBLE +: NIBBLE];
            end
        end
    endgenerate

    assign a_sel = a_nib[idx_reg];
    assign b_sel = b_nib[idx_reg];

    comp4 u_comp4 (
        .a    (a_sel),
        .b    (b_sel),
        .inE  (1'b1),
        .inL  (1'b0),
        .inG  (1'b0),
        .outE (res.e),
        .outL (res.l),
        .outG (res.g)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            signed_reg <= 1'b0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            eq_reg     <= 1'b0;
            lt_reg     <= 1'b0;
            gt_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg      <= a;
                        b_reg      <= b;
                        signed_reg <= signed_mode;
                        idx_reg    <= IDX_W'(NNIB - 1);
                        cnt_reg    <= '0;
                        eq_reg     <= 1'b0;
                        lt_reg     <= 1'b0;
                        gt_reg     <= 1'b0;
                        state_reg  <= COMPARE;
                    end
                end
                COMPARE: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (res.l) begin
                        lt_reg    <= 1'b1;
                        eq_reg    <= 1'b0;
                        gt_reg    <= 1'b0;
                        state_reg <= DONE;
                    end else if (res.g) begin
                        gt_reg    <= 1'b1;
                        eq_reg    <= 1'b0;
                        lt_reg    <= 1'b0;
                        state_reg <= DONE;
                    end else if (idx_reg == '0) begin
                        eq_reg    <= 1'b1;
                        lt_reg    <= 1'b0;
                        gt_reg    <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg - IDX_W'(1);
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy         = (state_reg == COMPARE);
    assign done         = (state_reg == DONE);
    assign eq           = eq_reg;
    assign lt           = lt_reg;
    assign gt           = gt_reg;
    assign nibbles_used = cnt_reg;

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Randomised scoreboard bench: the driver predicts accepts and pushes expected
// results; a monitor pops and checks them whenever done pulses.
module tb_serial_mag_compare_ctrl;

    localparam int W    = 16;
    localparam int NNIB = W / 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         signed_mode = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, eq, lt, gt;
    logic [2:0]   nibbles_used;

    serial_mag_compare_ctrl #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .signed_mode  (signed_mode),
        .a            (a),
        .b            (b),
        .busy         (busy),
        .done         (done),
        .eq           (eq),
        .lt           (lt),
        .gt           (gt),
        .nibbles_used (nibbles_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic eq;
        logic lt;
        logic gt;
        int   k;
        int   acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   free_edge = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic compare plus leading-equal-nibble count.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sm, input int acc);
        exp_t r;
        r.eq  = (av == bv);
        r.lt  = sm ? ($signed(av) < $signed(bv)) : (av < bv);
        r.gt  = sm ? ($signed(av) > $signed(bv)) : (av > bv);
        r.k   = 1;
        r.acc = acc;
        for (int i = NNIB - 1; i >= 1; i--) begin
            if (av[i*4 +: 4] != bv[i*4 +: 4]) break;
            r.k++;
        end
        return r;
    endfunction

    task automatic drive(input logic st, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sm, input logic rs);
        int   edge_no;
        exp_t e;
        @(negedge clk);
        start       = st;
        a           = av;
        b           = bv;
        signed_mode = sm;
        rst         = rs;
        edge_no     = cyc + 1;
        if (rs) begin
            sb.delete();
            free_edge = edge_no + 1;
        end else if (st && edge_no >= free_edge) begin
            e = model(av, bv, sm, edge_no);
            sb.push_back(e);
            $display("op: a=%h b=%h signed=%0b -> eq=%0b lt=%0b gt=%0b k=%0d", av, bv, sm,
                     e.eq, e.lt, e.gt, e.k);
            free_edge = edge_no + e.k + 2;
        end
    endtask

    task automatic wait_idle();
        while (cyc + 1 < free_edge) drive(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        check("busy_done_excl", {31'b0, busy & done}, 32'd0);
        if (busy) busy_cnt++;
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("flags", {29'b0, eq, lt, gt}, {29'b0, e.eq, e.lt, e.gt});
                check("nibbles_used", {29'b0, nibbles_used}, e.k);
                check("latency", cyc - e.acc, e.k);
                check("busy_cycles", busy_cnt, e.k);
            end
        end
        if (!busy && !done) busy_cnt = 0;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra, rb, mask;
        int           p;

        drive(1'b0, '0, '0, 1'b0, 1'b1);
        drive(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("reset_outs", {26'b0, busy, done, eq, lt, gt, nibbles_used}, 32'd0);

        drive(1'b1, 16'hC400, 16'h4400, 1'b0, 1'b0); wait_idle();
        drive(1'b1, 16'h1234, 16'h1234, 1'b0, 1'b0); wait_idle();
        drive(1'b1, 16'h12A4, 16'h12B0, 1'b0, 1'b0); wait_idle();
        drive(1'b1, 16'h8000, 16'h0001, 1'b1, 1'b0); wait_idle();
        drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b0); wait_idle();
        drive(1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b0); wait_idle();

        // Abort on the second compare cycle of an equal-operand compare.
        drive(1'b1, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("abort_outs", {26'b0, busy, done, eq, lt, gt, nibbles_used}, 32'd0);
        drive(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b0); wait_idle();

        // Start held mostly high with operands changing every cycle.
        for (int n = 0; n < 400; n++) begin
            ra   = W'($urandom);
            p    = $urandom_range(0, NNIB);
            mask = (p == NNIB) ? '0 : W'((32'h1 << ((p + 1) * 4)) - 1);
            rb   = (ra & ~mask) | (W'($urandom) & mask);
            drive($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)), 1'b0);
        end
        wait_idle();
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b0, '0, '0, 1'b0, 1'b0);
        check("sb_drain", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_mag_compare_ctrl.md
SERIAL_MAG_COMPARE_CTRL -- requirements
Module: serial_mag_compare_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to compare; sampled only in IDLE.
REQ-005 signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with operands.
REQ-006 a  input  WIDTH  operand A; captured on accepted start.
REQ-007 b  input  WIDTH  operand B; captured on accepted start.
REQ-008 busy  output  1  high while nibbles are being compared.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 eq / lt / gt  output  1 each  A==B / A<B / A>B; held until the next accepted start; exactly one is high after the first done.
REQ-011 nibbles_used  output  3 (clog2(WIDTH/4)+1 in general)  count of nibble compares the last operation consumed.

Function
REQ-012 FSM states IDLE, COMPARE, DONE; encoding free.
REQ-013 IDLE with start=1 at an edge SHALL latch a, b, signed_mode, set nibble index idx=WIDTH/4-1 and the nibble count to 0, and enter COMPARE.
REQ-014 IDLE with start=0 SHALL remain in IDLE.
REQ-015 start SHALL be ignored in COMPARE and DONE; latched operands SHALL NOT change mid-operation.
REQ-016 In COMPARE, each cycle SHALL compare nibble idx of the latched A and B, most significant nibble first, through one comp4 instance.
REQ-017 The comp4 cascade inputs SHALL be tied to E=1, L=0, G=0.
REQ-018 In signed_mode, bit 3 of both operands' most significant nibble SHALL be inverted before comparison; other nibbles SHALL be compared unsigned.
REQ-019 At each COMPARE edge the nibble count SHALL increment.
REQ-020 If the nibble result is L or G at a COMPARE edge, the unit SHALL register lt or gt, clear the other flags, and go to DONE (early exit).
REQ-021 If the nibble result is E and idx==0, the unit SHALL register eq=1 and go to DONE.
REQ-022 If the nibble result is E and idx>0, the unit SHALL decrement idx and stay in COMPARE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE; start asserted during DONE SHALL be ignored.
REQ-024 Latency: done SHALL be high k cycles after the start-accept edge, where k = 1 + (number of equal leading nibbles), bounded by WIDTH/4; nibbles_used = k.
REQ-025 busy SHALL equal (state==COMPARE); busy and done SHALL never be high together.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and busy=0, done=0, eq=0, lt=0, gt=0, nibbles_used=0, idx=0, and clear the operand registers.
REQ-027 rst SHALL take priority over start and all FSM transitions.
REQ-028 rst asserted mid-COMPARE SHALL abort the operation with no done pulse.

Structure
REQ-029 A shared package SHALL hold the state enum, the NIBBLE=4 constant and the cascade-result type {E,L,G}.
REQ-030 The sub-module comp4 SHALL be the team's 4-bit cascadable comparator (a, b, inE, inL, inG -> outE, outL, outG), purely combinational, with one instance only.
REQ-031 Expected implementation size is 120-250 RTL lines.

Verification
REQ-032 Unsigned, a=16'hC400, b=16'h4400 -> gt=1 and done 1 cycle after accept, nibbles_used=1.
REQ-033 Unsigned, a=b=16'h1234 -> eq=1 and done 4 cycles after accept, nibbles_used=4, busy high for exactly 4 cycles.
REQ-034 Unsigned, a=16'h12A4, b=16'h12B0 -> lt=1, nibbles_used=3; signed_mode=1, a=16'h8000, b=16'h0001 -> lt=1, nibbles_used=1.
REQ-035 Start pulsed on every cycle of an operation, with a and b toggled during busy -> exactly one done per accepted start; result uses the operands captured at accept.
REQ-036 rst on the 2nd COMPARE cycle of an a=b compare -> no done, all outputs 0 the next cycle; a following start with a=16'h0001, b=16'h0002 -> lt=1 and nibbles_used=4.
